iq_boxcar_decimator: RTL and testbench
======================================

// Module: iq_boxcar_decimator
// PURPOSE
//  Dual-channel (I/Q) integrate-and-dump decimator. Sums N consecutive valid
//  12-bit samples per channel and emits one full-precision sum per N inputs.
//  Sits directly upstream of the output saturator, which narrows the 17-bit
//  sums back to 12 bits for the sample FIFO.
// PARAMETERS
//  IW      12  input sample width, signed two's complement
//  OW      17  output sum width, signed; must be >= IW + clog2(DEC_MAX), else elaboration error
//  DEC_MAX 32  largest decimation ratio supported
//  DW      6   width of dec_ratio port; must be >= clog2(DEC_MAX+1)
// PORTS
//  clk        in   1   sole clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  dec_ratio  in   DW  decimation ratio N; 0 is treated as 1; values > DEC_MAX clamp to DEC_MAX
//  in_valid   in   1   in_i/in_q carry a sample this cycle
//  in_i       in   IW  signed I sample
//  in_q       in   IW  signed Q sample
//  out_valid  out  1   one-cycle strobe: out_i/out_q carry a new sum
//  out_i      out  OW  signed I sum of last N samples
//  out_q      out  OW  signed Q sum of last N samples
//  frame_pos  out  DW  samples accumulated in the current frame (0..N-1), for debug
// BEHAVIOUR
//  - Reset: out_valid=0, out_i=0, out_q=0, frame_pos=0, accumulators=0, N_lat=clamp(dec_ratio).
//  - N_lat is latched from dec_ratio only when frame_pos==0 and in_valid=1 (start of frame).
//    A dec_ratio change mid-frame takes effect on the next frame. The frame in progress
//    completes with the old N.
//  - Per channel on in_valid=1:
//      frame_pos==0:           acc <= sext(in)         (the previous sum is discarded)
//      otherwise:              acc <= acc + sext(in)
//      frame_pos==N_lat-1:     out <= acc + sext(in); out_valid <= 1; frame_pos <= 0
//      otherwise:              frame_pos <= frame_pos+1
//  - Latency: out_valid rises on the clock edge after the cycle carrying the N-th valid sample.
//    With N=1, each sample appears one cycle later, sign-extended.
//  - in_valid=0: accumulators, frame_pos and out_i/out_q hold. out_valid=0.
//    Gaps of any length are legal.
//  - out_valid is high for exactly one cycle per completed frame. Outputs hold between strobes.
//    There is no backpressure: the consumer must accept every strobe.
//  - Arithmetic: all sums are full precision in OW bits. With OW >= IW+clog2(DEC_MAX), no
//    overflow is possible. Worst case: 32 x -2048 = -65536, which fits in 17 bits.
//  - Reset during a frame discards the partial sum and aborts any pending strobe.
//    The first valid sample after reset starts a new frame.
//  - I and Q always share frame_pos, so they can never drift apart.
// STRUCTURE
//  - Shared package (icy_dsp_pkg): IW/OW defaults, DEC_MAX, and a clog2 function for the
//    width checks.
//  - Sub-module boxcar_acc:
//      * single-channel accumulator/dump register
//      * ports: clk, rst, en, first, last, din[IW], dout[OW]
//      * instantiated twice, for I and Q
//  - Top level owns:
//      * N_lat latch and clamp
//      * frame_pos counter
//      * out_valid register
// TESTING
//  1. N=4, continuous valid, in_i = 1,2,3,...,8 and in_q = -in_i.
//     Expect two strobes: out_i=10 then 26; out_q=-10 then -26.
//     The first strobe is 1 cycle after sample 4.
//  2. N=32, in_i=-2048 and in_q=+2047 held for 32 samples.
//     Expect out_i=-65536 (17'h10000) and out_q=65504, with no wrap.
//  3. dec_ratio=0, then dec_ratio=1, with a random stream.
//     Each sample must appear on the next cycle, sign-extended; out_valid mirrors delayed in_valid.
//  4. N=4 with in_valid toggling 1,0,0,1,0,1,1 and in_i=5 on each valid cycle.
//     Expect a single strobe with out_i=20, on the cycle after the 4th valid; no strobe before it.
//  5. N=4; change dec_ratio to 2 after the 2nd sample; input all ones.
//     Expect a first strobe of 4 (old N) followed by strobes of 2.
//  6. N=8; assert rst for 1 cycle after 5 samples of value 7, then feed 8 samples of 1.
//     Expect no strobe from the aborted frame, and the next strobe out_i=8.

Source files
------------

// File: rtl/icy_dsp_pkg.sv
// Shared DSP constants and helpers.
//   IW_DEF / OW_DEF / DEC_MAX_DEF / DW_DEF : default widths and decimation limit
//   clog2()                                : ceiling log2, used for elaboration width checks
package icy_dsp_pkg;

    localparam int unsigned IW_DEF      = 12;
    localparam int unsigned OW_DEF      = 17;
    localparam int unsigned DEC_MAX_DEF = 32;
    localparam int unsigned DW_DEF      = 6;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/boxcar_acc.sv
// Single-channel integrate-and-dump register.
//   clk, rst : clock, synchronous active-high reset
//   en       : din carries a sample this cycle
//   first    : sample starts a new frame (previous sum discarded)
//   last     : sample completes the frame; the full sum is dumped to dout
//   din      : signed IW-bit sample
//   dout     : signed OW-bit frame sum, held between dumps
module boxcar_acc
    import icy_dsp_pkg::*;
#(
    parameter int unsigned IW = IW_DEF,
    parameter int unsigned OW = OW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          first,
    input  logic          last,
    input  logic [IW-1:0] din,
    output logic [OW-1:0] dout
);

    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] dout_q;
    logic [OW-1:0] din_ext;

    assign din_ext = {{(OW-IW){din[IW-1]}}, din};

    always_comb begin
        acc_d = (first ? '0 : acc_q) + din_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            dout_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
            if (last) begin
                dout_q <= acc_d;
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/iq_boxcar_decimator.sv
// Dual-channel (I/Q) integrate-and-dump decimator: sums N valid samples per channel and
// emits one full-precision sum per N inputs.
//   clk, rst   : clock, synchronous active-high reset
//   dec_ratio  : decimation ratio N (0 -> 1, > DEC_MAX -> DEC_MAX), latched at frame start
//   in_valid   : in_i/in_q carry a sample
//   in_i, in_q : signed IW-bit samples
//   out_valid  : one-cycle strobe for a new out_i/out_q
//   out_i/out_q: signed OW-bit frame sums, held between strobes
//   frame_pos  : samples accumulated in the current frame
module iq_boxcar_decimator
    import icy_dsp_pkg::*;
#(
    parameter int unsigned IW      = IW_DEF,
    parameter int unsigned OW      = OW_DEF,
    parameter int unsigned DEC_MAX = DEC_MAX_DEF,
    parameter int unsigned DW      = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] dec_ratio,
    input  logic          in_valid,
    input  logic [IW-1:0] in_i,
    input  logic [IW-1:0] in_q,
    output logic          out_valid,
    output logic [OW-1:0] out_i,
    output logic [OW-1:0] out_q,
    output logic [DW-1:0] frame_pos
);

    if (OW < IW + clog2(DEC_MAX)) begin : g_ow_check
        $error("OW too narrow for IW and DEC_MAX");
    end
    if (DW < clog2(DEC_MAX + 1)) begin : g_dw_check
        $error("DW too narrow to hold DEC_MAX");
    end

    localparam logic [DW-1:0] DecMaxW = DW'(DEC_MAX);

    logic [DW-1:0] n_lat_q;
    logic [DW-1:0] frame_pos_q, frame_pos_d;
    logic          out_valid_q;
    logic [DW-1:0] n_in;
    logic [DW-1:0] n_cur;
    logic          first;
    logic          last;

    always_comb begin
        if (dec_ratio == '0) begin
            n_in = DW'(1);
        end else if (dec_ratio > DecMaxW) begin
            n_in = DecMaxW;
        end else begin
            n_in = dec_ratio;
        end
    end

    // The first sample of a frame must already see the new ratio, otherwise N=1 would
    // need two samples to close its first frame.
    assign first = (frame_pos_q == '0);
    assign n_cur = first ? n_in : n_lat_q;
    assign last  = (frame_pos_q == n_cur - DW'(1));

    always_comb begin
        frame_pos_d = frame_pos_q;
        if (in_valid) begin
            frame_pos_d = last ? '0 : frame_pos_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat_q     <= n_in;
            frame_pos_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid && last;
            frame_pos_q <= frame_pos_d;
            if (in_valid && first) begin
                n_lat_q <= n_in;
            end
        end
    end

    boxcar_acc #(
        .IW (IW),
        .OW (OW)
    ) u_acc_i (
        .clk   (clk),
        .rst   (rst),
        .en    (in_valid),
        .first (first),
        .last  (last),
        .din   (in_i),
        .dout  (out_i)
    );

    boxcar_acc #(
        .IW (IW),
        .OW (OW)
    ) u_acc_q (
        .clk   (clk),
        .rst   (rst),
        .en    (in_valid),
        .first (first),
        .last  (last),
        .din   (in_q),
        .dout  (out_q)
    );

    assign out_valid = out_valid_q;
    assign frame_pos = frame_pos_q;

endmodule

// File: tb/tb_iq_boxcar_decimator.sv
module tb_iq_boxcar_decimator;

    localparam int unsigned IW      = 12;
    localparam int unsigned OW      = 17;
    localparam int unsigned DEC_MAX = 32;
    localparam int unsigned DW      = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] dec_ratio;
    logic          in_valid;
    logic [IW-1:0] in_i;
    logic [IW-1:0] in_q;
    logic          out_valid;
    logic [OW-1:0] out_i;
    logic [OW-1:0] out_q;
    logic [DW-1:0] frame_pos;

    always #5 clk = ~clk;

    iq_boxcar_decimator #(
        .IW      (IW),
        .OW      (OW),
        .DEC_MAX (DEC_MAX),
        .DW      (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dec_ratio (dec_ratio),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_i     (out_i),
        .out_q     (out_q),
        .frame_pos (frame_pos)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: a frame is just the list of samples collected so far; when the list
    // reaches the ratio chosen at its first sample, the outputs become its sum.
    int     fr_i[$];
    int     fr_q[$];
    int     mod_n;
    bit     exp_valid = 1'b0;
    longint exp_i = 0;
    longint exp_q = 0;
    bit     chk_en = 1'b0;

    function automatic int clamp_ratio(input int r);
        if (r == 0) return 1;
        if (r > int'(DEC_MAX)) return int'(DEC_MAX);
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            fr_i.delete();
            fr_q.delete();
            mod_n     = clamp_ratio(int'(dec_ratio));
            exp_valid = 1'b0;
            exp_i     = 0;
            exp_q     = 0;
        end else begin
            exp_valid = 1'b0;
            if (in_valid) begin
                if (fr_i.size() == 0) mod_n = clamp_ratio(int'(dec_ratio));
                fr_i.push_back(int'($signed(in_i)));
                fr_q.push_back(int'($signed(in_q)));
                if (fr_i.size() == mod_n) begin
                    exp_i = 0;
                    exp_q = 0;
                    foreach (fr_i[k]) begin
                        exp_i += fr_i[k];
                        exp_q += fr_q[k];
                    end
                    exp_valid = 1'b1;
                    fr_i.delete();
                    fr_q.delete();
                end
            end
        end
    end

    // Strobe log for the hand-computed literal checks.
    longint log_i[$];
    longint log_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", longint'(out_valid), longint'(exp_valid));
            check("frame_pos", longint'(frame_pos), longint'(fr_i.size()));
            check("out_i", longint'($signed(out_i)), exp_i);
            check("out_q", longint'($signed(out_q)), exp_q);
            if (out_valid) begin
                log_i.push_back(longint'($signed(out_i)));
                log_q.push_back(longint'($signed(out_q)));
            end
        end
    end

    task automatic drive(input logic v, input int si, input int sq);
        in_valid = v;
        in_i     = IW'(si);
        in_q     = IW'(sq);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        log_i.delete();
        log_q.delete();
    endtask

    initial begin
        int nvalid;
        int last_s;
        rst       = 1'b1;
        dec_ratio = DW'(4);
        in_valid  = 1'b0;
        in_i      = '0;
        in_q      = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_i", longint'($signed(out_i)), 0);
        check("reset frame_pos", longint'(frame_pos), 0);

        // 1: N=4, ramp
        dec_ratio = DW'(4);
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, k, -k);
            if (k == 4) check("t1 strobe one cycle after 4th", longint'(out_valid), 1);
        end
        idle(2);
        check("t1 strobe count", log_i.size(), 2);
        if (log_i.size() == 2) begin
            check("t1 i0", log_i[0], 10);
            check("t1 i1", log_i[1], 26);
            check("t1 q0", log_q[0], -10);
            check("t1 q1", log_q[1], -26);
        end

        // 2: N=32 worst case
        dec_ratio = DW'(32);
        do_reset();
        for (int k = 0; k < 32; k++) drive(1'b1, -2048, 2047);
        idle(2);
        check("t2 strobe count", log_i.size(), 1);
        if (log_i.size() == 1) begin
            check("t2 i", log_i[0], -65536);
            check("t2 q", log_q[0], 65504);
        end
        check("t2 out_i raw bits", longint'(out_i), longint'(17'h10000));

        // 3: ratio 0 then 1, random stream
        for (int r = 0; r < 2; r++) begin
            dec_ratio = DW'(r);
            do_reset();
            nvalid = 0;
            last_s = 0;
            for (int k = 0; k < 24; k++) begin
                logic [IW-1:0] rv;
                logic          vv;
                rv = IW'($urandom_range(0, 4095));
                vv = ($urandom_range(0, 3) != 0);
                drive(vv, int'($signed(rv)), -int'($signed(rv)) / 2);
                check("t3 next-cycle strobe", longint'(out_valid), longint'(vv));
                if (vv) begin
                    nvalid++;
                    last_s = int'($signed(rv));
                    check("t3 next-cycle value", longint'($signed(out_i)), longint'(last_s));
                end
            end
            idle(1);
            check("t3 strobe count", log_i.size(), nvalid);
            check("t3 held value", longint'($signed(out_i)), longint'(last_s));
        end

        // 4: gaps
        dec_ratio = DW'(4);
        do_reset();
        drive(1'b1, 5, 0);
        drive(1'b0, 0, 0);
        drive(1'b0, 0, 0);
        drive(1'b1, 5, 0);
        drive(1'b0, 0, 0);
        drive(1'b1, 5, 0);
        check("t4 no early strobe", log_i.size(), 0);
        drive(1'b1, 5, 0);
        check("t4 strobe after 4th valid", longint'(out_valid), 1);
        idle(2);
        check("t4 strobe count", log_i.size(), 1);
        if (log_i.size() == 1) check("t4 i", log_i[0], 20);

        // 5: ratio change mid-frame
        dec_ratio = DW'(4);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1, -1);
            if (k == 1) dec_ratio = DW'(2);
        end
        idle(2);
        check("t5 strobe count", log_i.size(), 3);
        if (log_i.size() == 3) begin
            check("t5 i0", log_i[0], 4);
            check("t5 i1", log_i[1], 2);
            check("t5 i2", log_i[2], 2);
            check("t5 q0", log_q[0], -4);
        end

        // 6: reset mid-frame
        dec_ratio = DW'(8);
        do_reset();
        for (int k = 0; k < 5; k++) drive(1'b1, 7, 7);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) drive(1'b1, 1, 1);
        idle(2);
        check("t6 strobe count", log_i.size(), 1);
        if (log_i.size() == 1) check("t6 i", log_i[0], 8);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
